alu_share_arbiter: RTL and testbench

// - Shares the single 32-bit ALU between NUM_REQ requesters (e.g. execute datapath, address/branch unit).
// - Round-robin grant; valid/ready handshake per requester.
// - Two-stage pipeline: operand register drives the ALU, result register holds the response.
// - Tagged response with requester ID; backpressure via RSP_READY.

---
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between NUM_REQ requesters, with an operand stage and a result stage.
// Optional feature macro: ALU_ARB_BUSY_CNT_EN adds the BUSY_CNT output (cycles with an operand in flight).
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  output logic [NUM_REQ-1:0]    REQ_READY,
  input  logic [NUM_REQ*32-1:0] REQ_A,
  input  logic [NUM_REQ*32-1:0] REQ_B,
  input  logic [NUM_REQ*4-1:0]  REQ_SEL,
  output logic [31:0]           BUS_A,
  output logic [31:0]           BUS_B,
  output logic [3:0]            ALUSel,
  input  logic [31:0]           ALU_OUT,
  input  logic                  ZERO_FLAG,
  input  logic                  NEG_FLAG,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [IDW-1:0]        RSP_ID,
  output logic [31:0]           RSP_DATA,
  output logic                  RSP_ZERO,
`ifdef ALU_ARB_BUSY_CNT_EN
  output logic [31:0]           BUSY_CNT,
`endif
  output logic                  RSP_NEG
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [SW-1:0]  sel;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           zero;
    logic           neg;
  } rsp_t;

  op_t            op_q, op_d;
  logic           op_valid_q, op_valid_d;
  rsp_t           rsp_q, rsp_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic           rsp_free;
  logic           op_free;
  logic           accept;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;

  // Index arithmetic modulo NUM_REQ (both operands are always below NUM_REQ).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDW'(sum);
  endfunction

  // Round-robin search starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!grant_found && REQ_VALID[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign rsp_free  = !rsp_valid_q || RSP_READY;
  assign op_free   = !op_valid_q || rsp_free;
  assign accept    = grant_found && op_free && !RESET;
  assign REQ_READY = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  // Next-state for operand stage, result stage and round-robin pointer.
  always_comb begin
    op_d        = op_q;
    op_valid_d  = op_valid_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    rr_ptr_d    = rr_ptr_q;

    if (op_valid_q && rsp_free) begin
      rsp_d.id    = op_q.id;
      rsp_d.data  = ALU_OUT;
      rsp_d.zero  = ZERO_FLAG;
      rsp_d.neg   = NEG_FLAG;
      rsp_valid_d = 1'b1;
      op_valid_d  = 1'b0;
    end else if (rsp_valid_q && RSP_READY) begin
      rsp_valid_d = 1'b0;
    end

    if (accept) begin
      op_d.id    = grant_idx;
      op_d.a     = REQ_A[32'(grant_idx)*DW +: DW];
      op_d.b     = REQ_B[32'(grant_idx)*DW +: DW];
      op_d.sel   = REQ_SEL[32'(grant_idx)*SW +: SW];
      op_valid_d = 1'b1;
      rr_ptr_d   = wrap_add(grant_idx, 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q        <= '0;
      op_valid_q  <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      op_q        <= op_d;
      op_valid_q  <= op_valid_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // ALU sees zeros whenever the operand stage is empty.
  assign BUS_A  = op_valid_q ? op_q.a   : '0;
  assign BUS_B  = op_valid_q ? op_q.b   : '0;
  assign ALUSel = op_valid_q ? op_q.sel : '0;

  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_q.id;
  assign RSP_DATA  = rsp_q.data;
  assign RSP_ZERO  = rsp_q.zero;
  assign RSP_NEG   = rsp_q.neg;

`ifdef ALU_ARB_BUSY_CNT_EN
  logic [31:0] busy_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) busy_cnt_q <= '0;
    else       busy_cnt_q <= busy_cnt_q + 32'(op_valid_q);
  end

  assign BUSY_CNT = busy_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed steps then random traffic against a queue-based reference model.
module tb_alu_share_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned IDW     = 1;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [NUM_REQ-1:0]    REQ_VALID;
  logic [NUM_REQ-1:0]    REQ_READY;
  logic [NUM_REQ*32-1:0] REQ_A;
  logic [NUM_REQ*32-1:0] REQ_B;
  logic [NUM_REQ*4-1:0]  REQ_SEL;
  logic [31:0]           BUS_A;
  logic [31:0]           BUS_B;
  logic [3:0]            ALUSel;
  logic [31:0]           ALU_OUT;
  logic                  ZERO_FLAG;
  logic                  NEG_FLAG;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [IDW-1:0]        RSP_ID;
  logic [31:0]           RSP_DATA;
  logic                  RSP_ZERO;
  logic                  RSP_NEG;
`ifdef ALU_ARB_BUSY_CNT_EN
  logic [31:0]           BUSY_CNT;
`endif

  always #5 CLK = ~CLK;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_SEL(REQ_SEL),
    .BUS_A(BUS_A), .BUS_B(BUS_B), .ALUSel(ALUSel),
    .ALU_OUT(ALU_OUT), .ZERO_FLAG(ZERO_FLAG), .NEG_FLAG(NEG_FLAG),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_ZERO(RSP_ZERO),
`ifdef ALU_ARB_BUSY_CNT_EN
    .BUSY_CNT(BUSY_CNT),
`endif
    .RSP_NEG(RSP_NEG)
  );

  // Environment ALU: codes 0..9 implemented, the rest return 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      4'd9:    return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  assign ALU_OUT   = alu_f(BUS_A, BUS_B, ALUSel);
  assign ZERO_FLAG = (ALU_OUT == 32'h0);
  assign NEG_FLAG  = ALU_OUT[31];

  // Reference model: in-flight ops as a queue (capacity 2); 'fresh' marks an op accepted on the last edge.
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        zero;
    logic        neg;
    bit          fresh;
  } item_t;

  item_t       q[$];
  int          rr;
  int          busy_exp;
  int          checks;
  int          errors;
  logic [31:0] a_cur [NUM_REQ];
  logic [31:0] b_cur [NUM_REQ];
  logic [3:0]  s_cur [NUM_REQ];
  logic [31:0] hold_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    a_cur[i] = a;
    b_cur[i] = b;
    s_cur[i] = s;
    REQ_A[32*i +: 32] = a;
    REQ_B[32*i +: 32] = b;
    REQ_SEL[4*i +: 4] = s;
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge.
  task automatic step(input logic rst, input logic [NUM_REQ-1:0] vld, input logic rdy);
    int                 g;
    int                 idx;
    bit                 vis;
    bit                 op_busy;
    bit                 acc;
    logic [NUM_REQ-1:0] exp_rdy;
    item_t              it;
    @(negedge CLK);
    RESET     = rst;
    REQ_VALID = vld;
    RSP_READY = rdy;
    #1;
    vis     = (q.size() > 0) && !(q.size() == 1 && q[0].fresh);
    op_busy = (q.size() == 2) || (q.size() == 1 && q[0].fresh);
    g = -1;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (rr + k) % int'(NUM_REQ);
      if (g < 0 && vld[idx]) g = idx;
    end
    acc     = !rst && (g >= 0) && ((q.size() < 2) || (vis && rdy));
    exp_rdy = acc ? (NUM_REQ'(1) << g) : '0;
    chk("req_ready", 32'(REQ_READY), 32'(exp_rdy));
    chk("rsp_valid", 32'(RSP_VALID), 32'(vis));
    if (vis) begin
      chk("rsp_id",   32'(RSP_ID),   32'(q[0].id));
      chk("rsp_data", RSP_DATA,      q[0].data);
      chk("rsp_zero", 32'(RSP_ZERO), 32'(q[0].zero));
      chk("rsp_neg",  32'(RSP_NEG),  32'(q[0].neg));
    end
    if (op_busy) begin
      chk("bus_a",  BUS_A,        q[q.size()-1].a);
      chk("alusel", 32'(ALUSel),  32'(q[q.size()-1].sel));
    end else begin
      chk("bus_a_idle",  BUS_A,       32'h0);
      chk("alusel_idle", 32'(ALUSel), 32'h0);
    end
`ifdef ALU_ARB_BUSY_CNT_EN
    chk("busy_cnt", BUSY_CNT, 32'(busy_exp));
`endif
    @(posedge CLK);
    if (rst) begin
      q.delete();
      rr       = 0;
      busy_exp = 0;
    end else begin
      if (op_busy) busy_exp++;
      foreach (q[i]) q[i].fresh = 1'b0;
      if (vis && rdy) void'(q.pop_front());
      if (acc) begin
        it.id    = g;
        it.a     = a_cur[g];
        it.sel   = s_cur[g];
        it.data  = alu_f(a_cur[g], b_cur[g], s_cur[g]);
        it.zero  = (it.data == 32'h0);
        it.neg   = it.data[31];
        it.fresh = 1'b1;
        q.push_back(it);
        rr = (g + 1) % int'(NUM_REQ);
      end
    end
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RESET     = 1'b1;
    REQ_VALID = '0;
    RSP_READY = 1'b0;
    REQ_A     = '0;
    REQ_B     = '0;
    REQ_SEL   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) set_op(i, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge CLK);
    #1;
    q.delete();
    rr       = 0;
    busy_exp = 0;

    // Reset values
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    chk("rst_rsp_id",    32'(RSP_ID),    32'h0);
    chk("rst_rsp_data",  RSP_DATA,       32'h0);
    chk("rst_rsp_zero",  32'(RSP_ZERO),  32'h0);
    chk("rst_rsp_neg",   32'(RSP_NEG),   32'h0);
    step(1'b1, 2'b11, 1'b1);

    // Single op: 5 - 3
    set_op(0, 32'd5, 32'd3, 4'b0001);
    step(1'b0, 2'b01, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    chk("single_valid", 32'(RSP_VALID), 32'h1);
    chk("single_data",  RSP_DATA,       32'd2);
    chk("single_id",    32'(RSP_ID),    32'h0);
    chk("single_zero",  32'(RSP_ZERO),  32'h0);
    chk("single_neg",   32'(RSP_NEG),   32'h0);

    // Flags
    set_op(0, 32'd7, 32'd7, 4'b0001);
    step(1'b0, 2'b01, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    chk("zero_flag", 32'(RSP_ZERO), 32'h1);
    chk("zero_data", RSP_DATA,      32'h0);
    set_op(1, 32'd0, 32'd1, 4'b0001);
    step(1'b0, 2'b10, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    chk("neg_data", RSP_DATA,      32'hFFFF_FFFF);
    chk("neg_flag", 32'(RSP_NEG),  32'h1);
    chk("neg_id",   32'(RSP_ID),   32'h1);

    // Unsupported op code
    set_op(0, 32'd9, 32'd4, 4'b1111);
    step(1'b0, 2'b01, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    chk("bad_valid", 32'(RSP_VALID), 32'h1);
    chk("bad_data",  RSP_DATA,       32'h0);
    chk("bad_zero",  32'(RSP_ZERO),  32'h1);

    // Fairness: rr points at 1 here, so grants go 1,0,1,0...
    set_op(0, 32'd10, 32'd1, 4'b0000);
    set_op(1, 32'd20, 32'd2, 4'b0000);
    step(1'b0, 2'b11, 1'b1);
    chk("fair_first_empty", 32'(RSP_VALID), 32'h0);
    for (int k = 2; k <= 7; k++) begin
      step(1'b0, 2'b11, 1'b1);
      chk("fair_valid", 32'(RSP_VALID), 32'h1);
      chk("fair_id",    32'(RSP_ID),    (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    chk("drained", 32'(RSP_VALID), 32'h0);

    // Backpressure with two ops queued; rr points at 0 after seven alternating grants starting at 1
    set_op(0, 32'd50,  32'd8, 4'b0000);
    set_op(1, 32'd100, 32'd1, 4'b0001);
    step(1'b0, 2'b11, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    chk("bp_first_id", 32'(RSP_ID), 32'h0);
    hold_data = RSP_DATA;
    chk("bp_first_data", hold_data, 32'd58);
    step(1'b0, 2'b11, 1'b0);
    chk("bp_hold_data", RSP_DATA,    hold_data);
    chk("bp_hold_id",   32'(RSP_ID), 32'h0);
    step(1'b0, 2'b11, 1'b0);
    chk("bp_hold_data2", RSP_DATA,     hold_data);
    chk("bp_hold_valid", 32'(RSP_VALID), 32'h1);
    step(1'b0, 2'b00, 1'b1);
    chk("bp_second_id",   32'(RSP_ID), 32'h1);
    chk("bp_second_data", RSP_DATA,    32'd99);
    step(1'b0, 2'b00, 1'b1);
    chk("bp_empty", 32'(RSP_VALID), 32'h0);

    // Reset with an op in flight; afterwards requester 0 wins again
    step(1'b0, 2'b11, 1'b1);
    step(1'b1, 2'b11, 1'b1);
    chk("rst_mid_valid", 32'(RSP_VALID), 32'h0);
    step(1'b0, 2'b00, 1'b1);
    chk("rst_mid_dropped", 32'(RSP_VALID), 32'h0);
    step(1'b0, 2'b11, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    chk("rst_rr_valid", 32'(RSP_VALID), 32'h1);
    chk("rst_rr_id",    32'(RSP_ID),    32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        set_op(i, ra, rb, 4'($urandom_range(0, 15)));
      end
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           NUM_REQ'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
